// File: rtl/addsub_arb_pkg.sv
// Shared encodings for the two-requester add/sub arbiter and its datapath.
package addsub_arb_pkg;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/addsub_arb_cla.sv
// W-bit carry-lookahead add/sub: s = a + (b ^ {W{m}}) + m, with carry-out and signed overflow.
module addsub_cla
  import addsub_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic [W-1:0] s,
  output logic         c,
  output logic         v
);
  logic [W-1:0] bx, g, p;
  logic [W:0]   cy;
  logic         cin, pp;

  assign cin = (m == MODE_SUB);
  assign bx  = b ^ {W{cin}};
  assign g   = a & bx;
  assign p   = a ^ bx;

  // Each carry is a flat sum of generate terms gated by the propagates above them.
  always_comb begin
    cy    = '0;
    pp    = 1'b1;
    cy[0] = cin;
    for (int i = 0; i < W; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        cy[i+1] = cy[i+1] | (g[j] & pp);
        pp      = pp & p[j];
      end
      cy[i+1] = cy[i+1] | (pp & cin);
    end
  end

  assign s = p ^ cy[W-1:0];
  assign c = cy[W];
  assign v = cy[W] ^ cy[W-1];
endmodule

// File: rtl/addsub_arb.sv
// Round-robin arbiter feeding one shared add/sub unit; single registered response slot.
module addsub_arb
  import addsub_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_m,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_m,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_c,
  output logic         rsp_v
);
  state_t       state, state_nxt;
  logic         last_grant, gnt_vld, gnt_id, avail, accept;
  logic [W-1:0] mux_a, mux_b, dp_s;
  logic         mux_m, dp_c, dp_v;

  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = REQ0;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else if (req1_valid)          gnt_id = REQ1;
  end

  // rst_n gates the slot so nothing is accepted while reset is held.
  assign avail      = rst_n && ((state == ST_EMPTY) || rsp_ready);
  assign accept     = avail && gnt_vld;
  assign req0_ready = accept && (gnt_id == REQ0);
  assign req1_ready = accept && (gnt_id == REQ1);

  assign mux_a = (gnt_id == REQ1) ? req1_a : req0_a;
  assign mux_b = (gnt_id == REQ1) ? req1_b : req0_b;
  assign mux_m = gnt_vld ? ((gnt_id == REQ1) ? req1_m : req0_m) : MODE_ADD;

  addsub_cla #(.W(W)) u_cla (
    .a (mux_a),
    .b (mux_b),
    .m (mux_m),
    .s (dp_s),
    .c (dp_c),
    .v (dp_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept)                              state_nxt = ST_FULL;
    else if (state == ST_FULL && rsp_ready)  state_nxt = ST_EMPTY;
  end

  always_comb begin
    rsp_valid = (state == ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ1;
      rsp_id     <= REQ0;
      rsp_s      <= '0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
    end else if (accept) begin
      last_grant <= gnt_id;
      rsp_id     <= gnt_id;
      rsp_s      <= dp_s;
      rsp_c      <= dp_c;
      rsp_v      <= dp_v;
    end
  end
endmodule

// File: doc/addsub_arb.md
Name: addsub_arb

Overview:
Two-requester arbiter and sequencer for one shared W-bit add/sub carry-lookahead datapath. Each requester presents an operand pair and a mode (add/sub) with a valid/ready handshake. The block grants one requester per cycle using round-robin priority, registers the datapath result with its flags, and returns it on a single response channel tagged with the requester ID. It sits between the two operand producers and the single arithmetic unit, so the unit is never duplicated.

Parameters:
W, 4, operand and result width in bits (two's complement); must be >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 presents an operation
req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid
req0_a  input  W  requester 0 operand A (signed)
req0_b  input  W  requester 0 operand B (signed)
req0_m  input  1  requester 0 mode: 0 = A+B, 1 = A-B
req1_valid, req1_ready, req1_a, req1_b, req1_m  as requester 0, for requester 1
rsp_valid  output  1  response holds a valid result
rsp_ready  input  1  consumer accepts the response this cycle
rsp_id  output  1  requester index that owns the response
rsp_s  output  W  sum/difference
rsp_c  output  1  carry out of the MSB (for subtraction, 1 = no borrow)
rsp_v  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset (asynchronous, active-low, effective immediately): rsp_valid=0, rsp_id=0, rsp_s=0, rsp_c=0, rsp_v=0. The last_grant register resets to 1, so requester 0 wins the first contention. req*_ready is 0 while rst_n=0.
- FSM has 2 states:
  - EMPTY: no result held.
  - FULL: result held; rsp_valid=1 exactly in FULL.
- Slot available: avail = EMPTY, or (FULL and rsp_ready). This gives full throughput, one operation per cycle.
- Grant (combinational):
  - If only one reqX_valid is high, grant X.
  - If both are high, grant the requester other than last_grant.
  - If neither is high, no grant.
- reqX_ready = avail AND grant==X. Ready depends on valid; the ungranted requester sees ready=0.
- Acceptance (reqX_valid and reqX_ready at a rising edge):
  - The datapath computes A + (B XOR {W{M}}) + M on the granted operands in the same cycle.
  - S, C and V are registered into rsp_*; rsp_id=X; last_grant=X; state becomes FULL.
  - Latency is 1 cycle: the response is visible in the cycle after acceptance.
- Consume without new accept (FULL, rsp_ready=1, no valid request): state becomes EMPTY. rsp_s, rsp_c, rsp_v and rsp_id keep their last values.
- Consume and accept in the same cycle: the new result replaces the old one and the state stays FULL. No bubble.
- Backpressure (FULL, rsp_ready=0):
  - All rsp_* outputs stay stable.
  - Both ready outputs are 0; requesters must hold valid and their operands until accepted.
- Fairness: under continuous valid on both requesters, grants alternate 0,1,0,1,…; neither requester waits more than 1 grant.
- last_grant changes only on acceptance, never on idle cycles.
- Width rules:
  - S wraps modulo 2^W.
  - Overflow cases: -2^(W-1) - 1 gives V=1; (2^(W-1)-1) + 1 gives V=1.
  - A - 0 gives C=1, V=0.
- Reset asserted mid-operation discards any held result. Inputs presented during reset are not accepted.

Decomposition:
- Shared package constants: ST_EMPTY / ST_FULL state encoding, MODE_ADD=0 / MODE_SUB=1, REQ0=0 / REQ1=1.
- One sub-module: instantiate the existing addsub_cla (parameter W) as the shared datapath, fed by a 2:1 operand/mode mux driven by the grant.
- Arbitration, FSM and the output register stay in addsub_arb.

Test Plan:
- After reset, req0 A=5, B=3, M=0 alone -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_s=4'b1000, rsp_c=0, rsp_v=1.
- req1 A=3, B=5, M=1 alone -> rsp_s=4'b1110 (-2), rsp_c=0, rsp_v=0, rsp_id=1; then req1 A=-8, B=1, M=1 -> rsp_s=4'b0111, rsp_c=1, rsp_v=1; then A=0, B=0, M=1 -> rsp_s=0, rsp_c=1, rsp_v=0.
- Both requesters held valid, rsp_ready=1 for 6 cycles -> 6 back-to-back responses with rsp_id = 0,1,0,1,0,1 and no idle cycle between them.
- Hold rsp_ready=0 for 3 cycles with a response FULL and both requesters valid -> rsp_* unchanged, both ready outputs 0; on rsp_ready=1 the next grant is taken in that same cycle.
- Assert rst_n=0 while FULL with requests pending -> rsp_valid drops to 0 asynchronously (before the next clock edge); after release, the first contention is granted to requester 0.
- Random back-to-back operations on both requesters checked against a reference model: S = (A ± B) mod 16; C and V per the rules above; each requester's responses arrive in its own request order.
